// File: rtl/red_pitaya_ad5689_arbiter.sv
// Three-requester round-robin arbiter driving an AD5689 dual DAC over SPI.
// One 24-bit frame per grant: SYNC low for 24 SCLK periods (MSB first, data
// valid while SCLK is high, DAC samples on SCLK fall), a SYNC-high gap, then
// an optional LDAC pulse before the completion strobe.
// Optional feature macro: AD5689_ARB_LDAC_EN (enables the LDAC pulse state;
// when undefined the LDAC pin is tied low so the DAC updates on SYNC rise).
module red_pitaya_ad5689_arbiter #(
    parameter int SCLK_DIV    = 2,
    parameter int GAP_CYCLES  = 3,
    parameter int LDAC_CYCLES = 3
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [2:0]  req_i,
    input  logic [71:0] word_i,
    input  logic [2:0]  ldac_req_i,
    output logic [2:0]  gnt_o,
    output logic [2:0]  done_o,
    output logic        busy_o,
    output logic [23:0] rdata_o,
    output logic        dac_sclk,
    output logic        dac_sdin,
    output logic        dac_syncn,
    output logic        dac_ldacn,
    output logic        dac_rstn,
    input  logic        dac_sdo
);

    // One counter serves the SCLK phase, the gap and the LDAC pulse.
    localparam int CNT_MAX_A = (2 * SCLK_DIV > GAP_CYCLES) ? 2 * SCLK_DIV : GAP_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > LDAC_CYCLES) ? CNT_MAX_A : LDAC_CYCLES;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] HI_END   = CNT_W'(SCLK_DIV - 1);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(2 * SCLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(GAP_CYCLES - 1);
`ifdef AD5689_ARB_LDAC_EN
    localparam logic [CNT_W-1:0] LDAC_END = CNT_W'(LDAC_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
`ifdef AD5689_ARB_LDAC_EN
        , ST_LDAC
`endif
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [4:0]        r_bit;
    logic [23:0]       r_tx;
    logic [23:0]       r_rx;
    logic [1:0]        r_cur;
    logic [1:0]        r_ptr;
    logic [2:0]        r_gnt;
    logic [2:0]        r_done;
    logic [23:0]       r_rdata;
    logic              r_sclk;
    logic              r_syncn;
    logic              r_dac_rstn;

    state_t            w_state_next;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [4:0]        w_bit_next;
    logic [23:0]       w_tx_next;
    logic [23:0]       w_rx_next;
    logic [1:0]        w_cur_next;
    logic [1:0]        w_ptr_next;
    logic [2:0]        w_gnt_next;
    logic [2:0]        w_done_next;
    logic [23:0]       w_rdata_next;
    logic              w_sclk_next;
    logic              w_syncn_next;
    logic              w_finish;

`ifdef AD5689_ARB_LDAC_EN
    logic              r_ldac;
    logic              r_ldacn;
    logic              w_ldac_next;
    logic              w_ldacn_next;
`else
    // The per-requester LDAC flags have no effect in this build.
    logic              w_unused_ldac;
    assign w_unused_ldac = ^ldac_req_i;
`endif

    logic [23:0]       w_words [3];
    logic [2:0]        w_win_onehot;
    logic [1:0]        w_win_idx;
    logic              w_win_vld;
    logic [1:0]        w_ord0;
    logic [1:0]        w_ord1;
    logic [1:0]        w_ord2;

    // Split the packed word bus and decode the winner into a one-hot grant.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_req
            assign w_words[gi]      = word_i[24*gi +: 24];
            assign w_win_onehot[gi] = (w_win_idx == 2'(gi));
        end
    endgenerate

    // Round-robin pick: search starts one past the last granted requester.
    always_comb begin
        w_ord0 = 2'd0;
        w_ord1 = 2'd1;
        w_ord2 = 2'd2;
        case (r_ptr)
            2'd0:    begin w_ord0 = 2'd1; w_ord1 = 2'd2; w_ord2 = 2'd0; end
            2'd1:    begin w_ord0 = 2'd2; w_ord1 = 2'd0; w_ord2 = 2'd1; end
            default: begin w_ord0 = 2'd0; w_ord1 = 2'd1; w_ord2 = 2'd2; end
        endcase
        w_win_vld = |req_i;
        if (req_i[w_ord0])
            w_win_idx = w_ord0;
        else if (req_i[w_ord1])
            w_win_idx = w_ord1;
        else
            w_win_idx = w_ord2;
    end

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_bit_next   = r_bit;
        w_tx_next    = r_tx;
        w_rx_next    = r_rx;
        w_cur_next   = r_cur;
        w_ptr_next   = r_ptr;
        w_gnt_next   = r_gnt;
        w_done_next  = 3'b000;
        w_rdata_next = r_rdata;
        w_sclk_next  = r_sclk;
        w_syncn_next = r_syncn;
        w_finish     = 1'b0;
`ifdef AD5689_ARB_LDAC_EN
        w_ldac_next  = r_ldac;
        w_ldacn_next = r_ldacn;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_win_vld) begin
                    w_state_next = ST_SHIFT;
                    w_gnt_next   = w_win_onehot;
                    w_cur_next   = w_win_idx;
                    w_tx_next    = w_words[w_win_idx];
                    w_syncn_next = 1'b0;
                    w_sclk_next  = 1'b1;
                    w_cnt_next   = '0;
                    w_bit_next   = 5'd0;
`ifdef AD5689_ARB_LDAC_EN
                    w_ldac_next  = ldac_req_i[w_win_idx];
`endif
                end
            end
            ST_SHIFT: begin
                if (r_cnt == HI_END) begin
                    // SCLK falls here: the DAC takes dac_sdin, we take dac_sdo.
                    w_sclk_next = 1'b0;
                    w_rx_next   = {r_rx[22:0], dac_sdo};
                    w_cnt_next  = r_cnt + 1'b1;
                end else if (r_cnt == BIT_END) begin
                    w_cnt_next  = '0;
                    w_sclk_next = 1'b1;
                    if (r_bit == 5'd23) begin
                        w_state_next = ST_GAP;
                        w_syncn_next = 1'b1;
                        w_tx_next    = 24'h000000;
                    end else begin
                        w_bit_next = r_bit + 5'd1;
                        w_tx_next  = {r_tx[22:0], 1'b0};
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            ST_GAP: begin
                if (r_cnt == GAP_END) begin
                    w_cnt_next = '0;
`ifdef AD5689_ARB_LDAC_EN
                    if (r_ldac) begin
                        w_state_next = ST_LDAC;
                        w_ldacn_next = 1'b0;
                    end else begin
                        w_finish = 1'b1;
                    end
`else
                    w_finish = 1'b1;
`endif
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
`ifdef AD5689_ARB_LDAC_EN
            ST_LDAC: begin
                if (r_cnt == LDAC_END) begin
                    w_cnt_next   = '0;
                    w_ldacn_next = 1'b1;
                    w_finish     = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
`endif
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        // Common return path: strobe done, release grant, remember the winner.
        if (w_finish) begin
            w_state_next = ST_IDLE;
            w_gnt_next   = 3'b000;
            w_done_next  = r_gnt;
            w_rdata_next = r_rx;
            w_ptr_next   = r_cur;
        end
    end

    // State and output registers; reset returns the bus to its idle levels.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_bit      <= 5'd0;
            r_tx       <= 24'h000000;
            r_rx       <= 24'h000000;
            r_cur      <= 2'd0;
            r_ptr      <= 2'd2;
            r_gnt      <= 3'b000;
            r_done     <= 3'b000;
            r_rdata    <= 24'h000000;
            r_sclk     <= 1'b1;
            r_syncn    <= 1'b1;
            r_dac_rstn <= 1'b0;
`ifdef AD5689_ARB_LDAC_EN
            r_ldac     <= 1'b0;
            r_ldacn    <= 1'b1;
`endif
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_bit      <= w_bit_next;
            r_tx       <= w_tx_next;
            r_rx       <= w_rx_next;
            r_cur      <= w_cur_next;
            r_ptr      <= w_ptr_next;
            r_gnt      <= w_gnt_next;
            r_done     <= w_done_next;
            r_rdata    <= w_rdata_next;
            r_sclk     <= w_sclk_next;
            r_syncn    <= w_syncn_next;
            r_dac_rstn <= 1'b1;
`ifdef AD5689_ARB_LDAC_EN
            r_ldac     <= w_ldac_next;
            r_ldacn    <= w_ldacn_next;
`endif
        end
    end

    assign gnt_o     = r_gnt;
    assign done_o    = r_done;
    assign busy_o    = (r_state != ST_IDLE);
    assign rdata_o   = r_rdata;
    assign dac_sclk  = r_sclk;
    // Data bit comes straight from the frame register MSB, so it moves only
    // when that register shifts (at the SCLK rising edge) and is 0 when idle.
    assign dac_sdin  = r_tx[23];
    assign dac_syncn = r_syncn;
    assign dac_rstn  = r_dac_rstn;
`ifdef AD5689_ARB_LDAC_EN
    assign dac_ldacn = r_ldacn;
`else
    assign dac_ldacn = 1'b0;
`endif

endmodule

// File: tb/tb_red_pitaya_ad5689_arbiter.sv
// Self-checking bench for red_pitaya_ad5689_arbiter: decodes the SPI pins
// into frames and compares them with a round-robin reference model.
// Honours AD5689_ARB_LDAC_EN the same way as the design.
module tb_red_pitaya_ad5689_arbiter;

    localparam int SCLK_DIV    = 2;
    localparam int GAP_CYCLES  = 3;
    localparam int LDAC_CYCLES = 3;
`ifdef AD5689_ARB_LDAC_EN
    localparam bit LDAC_EN = 1'b1;
`else
    localparam bit LDAC_EN = 1'b0;
`endif

    logic        clk_i;
    logic        rstn_i;
    logic [2:0]  req_i;
    logic [71:0] word_i;
    logic [2:0]  ldac_req_i;
    logic [2:0]  gnt_o;
    logic [2:0]  done_o;
    logic        busy_o;
    logic [23:0] rdata_o;
    logic        dac_sclk;
    logic        dac_sdin;
    logic        dac_syncn;
    logic        dac_ldacn;
    logic        dac_rstn;
    logic        dac_sdo;

    int n_tests;
    int n_fail;
    int n_frames;
    int rr_ptr;   // reference model: index of the last requester served

    red_pitaya_ad5689_arbiter #(
        .SCLK_DIV    (SCLK_DIV),
        .GAP_CYCLES  (GAP_CYCLES),
        .LDAC_CYCLES (LDAC_CYCLES)
    ) dut (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .req_i      (req_i),
        .word_i     (word_i),
        .ldac_req_i (ldac_req_i),
        .gnt_o      (gnt_o),
        .done_o     (done_o),
        .busy_o     (busy_o),
        .rdata_o    (rdata_o),
        .dac_sclk   (dac_sclk),
        .dac_sdin   (dac_sdin),
        .dac_syncn  (dac_syncn),
        .dac_ldacn  (dac_ldacn),
        .dac_rstn   (dac_rstn),
        .dac_sdo    (dac_sdo)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] rand24();
        return 24'($urandom);
    endfunction

    // Round-robin rule: first requesting index after the last one served.
    function automatic int rr_pick(input logic [2:0] req, input int ptr);
        for (int k = 1; k <= 3; k++) begin
            int c;
            c = (ptr + k) % 3;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [2:0] onehot(input int idx);
        return 3'b001 << idx;
    endfunction

    task automatic check_reset_vals(input string pfx);
        check_val({pfx, "_gnt"},   gnt_o,     32'd0);
        check_val({pfx, "_done"},  done_o,    32'd0);
        check_val({pfx, "_busy"},  busy_o,    32'd0);
        check_val({pfx, "_rdata"}, rdata_o,   32'd0);
        check_val({pfx, "_sclk"},  dac_sclk,  32'd1);
        check_val({pfx, "_syncn"}, dac_syncn, 32'd1);
        check_val({pfx, "_sdin"},  dac_sdin,  32'd0);
        check_val({pfx, "_ldacn"}, dac_ldacn, LDAC_EN ? 32'd1 : 32'd0);
        check_val({pfx, "_rstn"},  dac_rstn,  32'd0);
    endtask

    // Observe one complete transaction from grant to done, playing the DAC's
    // readback on dac_sdo. Called at a falling clock edge with inputs set.
    task automatic run_frame(input int exp_idx, input logic [23:0] exp_word,
                             input bit exp_ldac, input logic [23:0] sdo_word,
                             input bit clobber);
        int waitc, syncn_low, falls, gapc, ldacc, cyc, bad_sdin, bad_order, bad_ldac;
        logic [23:0] rx;
        logic prev_sclk, prev_sdin;
        bit got_done;
        dac_sdo = sdo_word[23];
        @(negedge clk_i);
        check_val("done_single_cycle", done_o, 32'd0);
        waitc = 1;
        while (gnt_o == 3'b000 && waitc < 50) begin
            @(negedge clk_i);
            waitc++;
        end
        check_val("gnt_seen", |gnt_o, 32'd1);
        if (gnt_o == 3'b000) return;
        check_val("gnt_winner", gnt_o, onehot(exp_idx));
        check_val("busy_in_frame", busy_o, 32'd1);
        if (clobber) word_i[24*exp_idx +: 24] = 24'h000000;
        prev_sclk = dac_sclk;
        prev_sdin = dac_sdin;
        syncn_low = 0; falls = 0; gapc = 0; ldacc = 0; cyc = 0;
        bad_sdin = 0; bad_order = 0; bad_ldac = 0;
        rx = 24'h0;
        got_done = 1'b0;
        while (!got_done && cyc < 3000) begin
            if (done_o != 3'b000) begin
                got_done = 1'b1;
            end else begin
                if (!dac_syncn) begin
                    syncn_low++;
                    if (LDAC_EN && dac_ldacn !== 1'b1) bad_ldac++;
                end else if (LDAC_EN && dac_ldacn == 1'b0) begin
                    ldacc++;
                end else begin
                    gapc++;
                    if (ldacc > 0) bad_order++;
                end
                if (!LDAC_EN && dac_ldacn !== 1'b0) bad_ldac++;
                if (falls < 24) dac_sdo = sdo_word[23 - falls];
                @(negedge clk_i);
                cyc++;
                if (prev_sclk && !dac_sclk && !dac_syncn) begin
                    rx = {rx[22:0], prev_sdin};
                    falls++;
                end
                if (dac_sdin !== prev_sdin && !dac_syncn && !(!prev_sclk && dac_sclk))
                    bad_sdin++;
                prev_sclk = dac_sclk;
                prev_sdin = dac_sdin;
            end
        end
        check_val("done_seen", got_done, 32'd1);
        if (!got_done) return;
        check_val("done_target", done_o, onehot(exp_idx));
        check_val("gnt_dropped", gnt_o, 32'd0);
        check_val("busy_at_done", busy_o, 32'd0);
        check_val("rdata", rdata_o, sdo_word);
        check_val("sdin_word", rx, exp_word);
        check_val("sclk_falls", falls, 32'd24);
        check_val("syncn_low_cycles", syncn_low, 32'(48 * SCLK_DIV));
        check_val("gap_cycles", gapc, GAP_CYCLES);
        check_val("ldac_cycles", ldacc, (LDAC_EN && exp_ldac) ? LDAC_CYCLES : 0);
        check_val("ldac_after_gap", bad_order, 32'd0);
        check_val("ldacn_level", bad_ldac, 32'd0);
        check_val("sdin_stable", bad_sdin, 32'd0);
        rr_ptr = exp_idx;
        n_frames++;
        $display("[TB] frame %0d: gnt=%0d word=0x%06h sent=0x%06h rdata=0x%06h ldac_cycles=%0d",
                 n_frames, exp_idx, exp_word, rx, rdata_o, ldacc);
    endtask

    // Pick the model's winner and run a frame for it.
    task automatic model_frame(input logic [23:0] sdo_word, input bit clobber);
        int idx;
        idx = rr_pick(req_i, rr_ptr);
        if (idx < 0) idx = 0;
        run_frame(idx, word_i[24*idx +: 24], ldac_req_i[idx], sdo_word, clobber);
    endtask

    initial begin
        int falls, waitc, bad_after;
        logic prev_sclk;
        n_tests = 0; n_fail = 0; n_frames = 0; rr_ptr = 2;
        rstn_i = 1'b0; req_i = 3'b000; word_i = 72'h0; ldac_req_i = 3'b000; dac_sdo = 1'b0;

        // Reset values and the DAC reset release.
        repeat (3) @(negedge clk_i);
        check_reset_vals("reset");
        rstn_i = 1'b1;
        #1 check_val("dac_rstn_before_edge", dac_rstn, 32'd0);
        @(negedge clk_i);
        check_val("dac_rstn_after_edge", dac_rstn, 32'd1);
        check_val("busy_idle", busy_o, 32'd0);

        // All three requesting continuously: strict rotation 0,1,2,0,1.
        req_i = 3'b111;
        for (int i = 0; i < 5; i++) begin
            word_i = {rand24(), rand24(), rand24()};
            model_frame(rand24(), 1'b0);
        end

        // A request withdrawn while idle is simply never served.
        req_i = 3'b000;
        repeat (6) @(negedge clk_i);
        check_val("dropped_no_gnt", gnt_o, 32'd0);
        check_val("dropped_not_busy", busy_o, 32'd0);
        check_val("dropped_syncn", dac_syncn, 32'd1);

        // Known word from requester 0, no LDAC.
        req_i = 3'b001; ldac_req_i = 3'b000;
        word_i = {rand24(), rand24(), 24'h31ABCD};
        model_frame(rand24(), 1'b0);

        // Known readback pattern.
        word_i = {rand24(), rand24(), rand24()};
        model_frame(24'hA5A5A5, 1'b0);

        // LDAC pulse requested by requester 1.
        req_i = 3'b010; ldac_req_i = 3'b010;
        word_i = {rand24(), rand24(), rand24()};
        model_frame(rand24(), 1'b0);

        // Word input cleared right after grant; captured copy goes out.
        req_i = 3'b001; ldac_req_i = 3'b000;
        word_i = {rand24(), rand24(), rand24()};
        model_frame(rand24(), 1'b1);

        // Random request patterns, words, LDAC flags and readback.
        for (int i = 0; i < 20; i++) begin
            req_i      = 3'($urandom_range(1, 7));
            ldac_req_i = 3'($urandom);
            word_i     = {rand24(), rand24(), rand24()};
            model_frame(rand24(), 1'b0);
        end

        // Reset asserted at bit 10 of a frame.
        req_i = 3'b001; ldac_req_i = 3'b000;
        word_i = {rand24(), rand24(), rand24()};
        waitc = 0;
        @(negedge clk_i);
        while (gnt_o == 3'b000 && waitc < 50) begin
            @(negedge clk_i);
            waitc++;
        end
        check_val("abort_gnt_seen", |gnt_o, 32'd1);
        falls = 0; waitc = 0;
        prev_sclk = dac_sclk;
        while (falls < 10 && waitc < 500) begin
            @(negedge clk_i);
            waitc++;
            if (prev_sclk && !dac_sclk) falls++;
            prev_sclk = dac_sclk;
        end
        check_val("abort_reached_bit10", falls, 32'd10);
        #2 rstn_i = 1'b0;
        #1 check_reset_vals("abort_async");
        req_i = 3'b000;
        repeat (3) @(negedge clk_i);
        check_reset_vals("abort_held");
        rstn_i = 1'b1;
        rr_ptr = 2;
        bad_after = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            if (done_o != 3'b000 || busy_o || !dac_syncn) bad_after++;
        end
        check_val("abort_no_resume", bad_after, 32'd0);

        // Pointer back at its reset position: requester 0 wins first.
        req_i = 3'b111;
        word_i = {rand24(), rand24(), rand24()};
        model_frame(rand24(), 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/red_pitaya_ad5689_arbiter.md
RED_PITAYA_AD5689_ARBITER -- requirements
Module: red_pitaya_ad5689_arbiter

Interface
REQ-001 SHALL have parameter SCLK_DIV, default 2, clk_i cycles per SCLK half-period (31.25 MHz at 125 MHz).
REQ-002 SHALL have parameter GAP_CYCLES, default 3, minimum dac_syncn high time between frames.
REQ-003 SHALL have parameter LDAC_CYCLES, default 3, dac_ldacn low pulse width.
REQ-004 SHALL have port clk_i, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rstn_i, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port req_i, input, 3: level request per requester 0..2.
REQ-007 SHALL have port word_i, input, 72: packed 24-bit SPI words, requester n at bits [24n+23:24n].
REQ-008 SHALL have port ldac_req_i, input, 3: per-requester "pulse LDAC after frame" flag.
REQ-009 SHALL have port gnt_o, output, 3: one-hot grant, held for the whole transaction.
REQ-010 SHALL have port done_o, output, 3: one-cycle completion pulse to the granted requester.
REQ-011 SHALL have port busy_o, output, 1: high when not IDLE.
REQ-012 SHALL have port rdata_o, output, 24: word shifted in from dac_sdo during the last frame.
REQ-013 SHALL have ports dac_sclk, dac_sdin, dac_syncn, dac_ldacn, dac_rstn, output, 1 each, and dac_sdo, input, 1: AD5689 SPI pins.

Function
REQ-014 SHALL implement states IDLE, SHIFT, GAP, LDAC.
REQ-015 SHALL arbitrate only in IDLE, round-robin: search starts at last-granted+1 (mod 3); pointer starts so requester 0 wins first after reset.
REQ-016 SHALL, on the edge after a request is seen in IDLE, set gnt_o, drive dac_syncn low, capture the granted 24-bit word and ldac flag, and enter SHIFT; later word_i changes SHALL be ignored.
REQ-017 SHALL shift 24 bits MSB first in SHIFT: per bit dac_sclk high SCLK_DIV cycles with dac_sdin valid, then low SCLK_DIV cycles; dac_sdin changes only at the sclk rising edge; SHIFT lasts exactly 48*SCLK_DIV cycles.
REQ-018 SHALL sample dac_sdo on each sclk falling edge into a shift register, MSB first, and copy it to rdata_o on the done_o cycle.
REQ-019 SHALL, after SHIFT, drive dac_syncn high and dac_sclk high for GAP_CYCLES in GAP.
REQ-020 SHALL, after GAP, enter LDAC if the captured ldac flag is set (see REQ-029), driving dac_ldacn low exactly LDAC_CYCLES cycles; else return to IDLE.
REQ-021 SHALL assert done_o[n] for one cycle on the edge returning to IDLE, drop gnt_o on the same edge, and update the round-robin pointer to n.
REQ-022 SHALL treat req_i[n] still high during/after its done_o as a new request, granted in rotation order, never back-to-back while another requester waits.
REQ-023 SHALL ignore req_i changes while not IDLE; a request dropped before grant is lost without done_o.
REQ-024 SHALL have idle bus levels: dac_sclk=1, dac_syncn=1, dac_sdin=0, dac_ldacn=1.

Reset
REQ-025 SHALL, while rstn_i=0, immediately force: state IDLE, gnt_o=0, done_o=0, busy_o=0, rdata_o=0, dac_sclk=1, dac_syncn=1, dac_sdin=0, dac_ldacn=1, dac_rstn=0, pointer to requester 0.
REQ-026 SHALL drive dac_rstn high on the first clk_i edge after rstn_i release.
REQ-027 SHALL abort any frame on reset mid-operation with no done_o pulse; no frame resumes after release.

Configuration
REQ-028 SHALL use macro AD5689_ARB_LDAC_EN.
REQ-029 SHALL, with AD5689_ARB_LDAC_EN defined, implement the LDAC state per REQ-020; without it, omit the LDAC state, ignore ldac_req_i, and tie dac_ldacn to 0 (DAC updates on dac_syncn rise).

Verification
REQ-030 SHALL cover req_i=001, word0=0x31ABCD, ldac=0 -> dac_sdin sampled at 24 sclk falls = 0x31ABCD, dac_syncn low 96 cycles, one done_o[0], dac_ldacn stays 1.
REQ-031 SHALL cover req_i=111 held -> grants 0,1,2,0,1 in order, gap dac_syncn high >=3 cycles each.
REQ-032 SHALL cover ldac_req_i[1]=1 with macro -> dac_ldacn low exactly 3 cycles after GAP, before done_o[1]; without macro dac_ldacn constant 0.
REQ-033 SHALL cover dac_sdo driving 0xA5A5A5 -> rdata_o=0xA5A5A5 on done_o cycle.
REQ-034 SHALL cover rstn_i low at bit 10 -> all outputs at reset values asynchronously, no done_o, IDLE after release.
REQ-035 SHALL cover word0 changed to 0x000000 one cycle after grant -> original captured word transmitted.
